pixel_frame_server: RTL and testbench
=====================================

Name: pixel_frame_server

Overview:
- Image-side partner of GarbageSortTop: captures one streamed RGB frame into an on-chip buffer, then starts the network with conv_start.
- Answers the network's read_addr requests with pixel data on d_in.
- Captures net_out when the network raises net_complete and holds the classification until the host acknowledges it.
- Sits between the camera/DMA pixel stream and the network top.

Parameters:
- IMG_PIX, 1024, pixels per frame; read_addr space is 0..IMG_PIX-1.
- PIX_W, 24, RGB pixel width.
- ADDR_W, 10, address width; must satisfy 2^ADDR_W >= IMG_PIX.
- START_LEN, 100, cycles conv_start is held high after entering RUN.
- TIMEOUT, 200000, maximum RUN cycles before the frame is abandoned.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- pix_valid  in  1  stream pixel valid.
- pix_sof  in  1  start of frame; qualified by pix_valid.
- pix_data  in  PIX_W  stream pixel.
- pix_ready  out  1  block accepts stream pixels.
- conv_start  out  1  network start level.
- read_addr  in  ADDR_W  network pixel read address.
- d_in  out  PIX_W  pixel returned to the network.
- net_out  in  8  network class result.
- net_complete  in  1  network done.
- result_valid  out  1  result held for the host.
- result_class  out  8  captured class.
- result_timeout  out  1  result was produced by a timeout.
- result_ack  in  1  host consumed the result.
- frame_drop  out  1  one-cycle pulse on a stream framing error.
- busy  out  1  state != FILL.

Behaviour:
- Reset (rst=0 sampled at posedge):
  - state=FILL, wptr=0, run counter=0.
  - All outputs 0, including pix_ready, d_in and result_class.
  - A reset in any state abandons the frame. Buffer contents are don't-care.
- FILL state:
  - pix_ready=1.
  - A beat is accepted when pix_valid=1.
  - Accepted beat with pix_sof=1: written to address 0, wptr<=1. If wptr!=0 at that moment, frame_drop pulses (partial frame discarded).
  - Accepted beat with pix_sof=0 and wptr=0: discarded, frame_drop pulses, wptr unchanged.
  - Otherwise: written to address wptr, wptr increments.
  - When the written address is IMG_PIX-1: next state is RUN, wptr<=0, run counter<=0.
- RUN state:
  - pix_ready=0.
  - conv_start=1 from the first RUN cycle for START_LEN cycles, then 0.
  - conv_start drops immediately (same edge as the transition) if net_complete is seen earlier.
  - The run counter increments every cycle.
  - net_complete=1 sampled: result_class<=net_out, result_timeout<=0, go to DONE.
  - Run counter reaches TIMEOUT-1 without net_complete: result_class<=8'hFF, result_timeout<=1, go to DONE.
  - If both happen in the same cycle, net_complete wins.
- DONE state:
  - result_valid=1. result_class and result_timeout are stable.
  - conv_start=0, pix_ready=0.
  - result_ack=1 sampled: result_valid<=0, go to FILL next cycle.
  - result_ack is ignored in all other states.
- Read port (every state):
  - d_in <= mem[read_addr] registered, 1-cycle latency.
  - read_addr >= IMG_PIX returns 0.
  - A read and a write to the same address in the same cycle return the old data. This cannot occur in RUN.
- Widths:
  - Counters are unsigned. The run counter is wide enough for TIMEOUT.
  - wptr wraps only via the explicit reset to 0; it never exceeds IMG_PIX-1.

Decomposition:
- Shared package/header holds:
  - the state encodings FILL=2'd0, RUN=2'd1, DONE=2'd2;
  - CLASS_TIMEOUT=8'hFF;
  - defaults for IMG_PIX, PIX_W and ADDR_W, reused by GarbageSortTop.
- One sub-module, pixel_ram: simple dual-port RAM with 1 write port and 1 synchronous read port, depth IMG_PIX, width PIX_W. Read-during-write returns old data.
- The FSM, counters and result register stay in pixel_frame_server.

Test Plan:
- Reset, then stream 1024 beats (SOF on the first, data=address).
  - pix_ready drops the cycle after beat 1023; conv_start is high for exactly 100 cycles.
  - read_addr=5 gives d_in=24'd5 one cycle later; read_addr=1023 gives 24'd1023.
- In RUN, drive net_complete=1 with net_out=8'd3 at run cycle 40.
  - conv_start falls at that edge; result_valid=1, result_class=3, result_timeout=0.
  - result_ack → FILL and pix_ready=1 on the next cycle.
- Framing errors:
  - Stream 10 beats, then SOF on beat 11 → frame_drop pulses once and that beat lands at address 0.
  - A beat without SOF at wptr=0 → frame_drop pulses and the beat is not written.
- Timeout: run with TIMEOUT=300 and never assert net_complete.
  - DONE is entered after 300 RUN cycles with result_class=8'hFF, result_timeout=1.
  - With net_complete asserted in the timeout cycle instead → result_timeout=0.
- Reset mid-operation: drop rst for 1 cycle mid-FILL (wptr=500) and again mid-RUN.
  - All outputs are 0 and the state is FILL.
  - A fresh full frame then completes normally.
- Read edge cases: read_addr=1023/1024 returns data/0; result_ack asserted during FILL or RUN is ignored.

Source files
------------

// File: rtl/pixel_frame_server_pkg.sv
// Shared types and defaults for the pixel frame server and the network top that consumes it.
package pixel_frame_server_pkg;

  localparam int IMG_PIX_DEF = 1024;
  localparam int PIX_W_DEF   = 24;
  localparam int ADDR_W_DEF  = 10;

  localparam logic [7:0] CLASS_TIMEOUT = 8'hFF;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0] cls;
    logic       timeout;
  } result_t;

endpackage

// File: rtl/pixel_frame_server_if.sv
// Pixel stream, network read/result and host result signals of the frame server.
interface pixel_frame_server_if #(
  parameter int PIX_W  = pixel_frame_server_pkg::PIX_W_DEF,
  parameter int ADDR_W = pixel_frame_server_pkg::ADDR_W_DEF
);
  logic              pix_valid;
  logic              pix_sof;
  logic [PIX_W-1:0]  pix_data;
  logic              pix_ready;
  logic              conv_start;
  logic [ADDR_W-1:0] read_addr;
  logic [PIX_W-1:0]  d_in;
  logic [7:0]        net_out;
  logic              net_complete;
  logic              result_valid;
  logic [7:0]        result_class;
  logic              result_timeout;
  logic              result_ack;
  logic              frame_drop;
  logic              busy;

  // slave: the frame server itself
  modport slave (
    input  pix_valid, pix_sof, pix_data, read_addr, net_out, net_complete, result_ack,
    output pix_ready, conv_start, d_in, result_valid, result_class, result_timeout,
           frame_drop, busy
  );

  // master: stream source, network and host seen together
  modport master (
    output pix_valid, pix_sof, pix_data, read_addr, net_out, net_complete, result_ack,
    input  pix_ready, conv_start, d_in, result_valid, result_class, result_timeout,
           frame_drop, busy
  );
endinterface

// File: rtl/pixel_frame_server_pixel_ram.sv
// Frame buffer: one write port, one registered read port (1-cycle latency, old data on collision).
// Out-of-range addresses write nothing and read back zero.
module pixel_ram #(
  parameter int DEPTH  = 1024,
  parameter int WIDTH  = 24,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we && (int'(waddr) < DEPTH)) begin
      mem[waddr[IDX_W-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata <= '0;
    end else if (int'(raddr) < DEPTH) begin
      rdata <= mem[raddr[IDX_W-1:0]];
    end else begin
      rdata <= '0;
    end
  end
endmodule

// File: rtl/pixel_frame_server.sv
// Captures one streamed frame, runs the network over it and holds its class until the host acks.
// Pixel reads answer in 1 cycle; pix_ready is high only while filling.
module pixel_frame_server
  import pixel_frame_server_pkg::*;
#(
  parameter int IMG_PIX   = IMG_PIX_DEF,
  parameter int PIX_W     = PIX_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int START_LEN = 100,
  parameter int TIMEOUT   = 200000
) (
  input logic                 clk,
  input logic                 rst,
  pixel_frame_server_if.slave bus
);
  localparam int                CNT_W      = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  RUN_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  START_LAST = CNT_W'(START_LEN - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(IMG_PIX - 1);

  state_t            state, state_n;
  logic [ADDR_W-1:0] wptr, wptr_n;
  logic [CNT_W-1:0]  run_cnt, run_cnt_n;
  logic              conv_q, conv_n;
  logic              ready_q, ready_n;
  logic              drop_q, drop_n;
  logic              rv_q, rv_n;
  result_t           res_q, res_n;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [PIX_W-1:0]  rd_data;
  logic              accept;

  assign accept = bus.pix_valid && ready_q;

  always_comb begin
    state_n   = state;
    wptr_n    = wptr;
    run_cnt_n = run_cnt;
    conv_n    = 1'b0;
    drop_n    = 1'b0;
    rv_n      = rv_q;
    res_n     = res_q;
    we        = 1'b0;
    waddr     = wptr;
    unique case (state)
      FILL: begin
        if (accept) begin
          if (bus.pix_sof) begin
            // SOF always restarts the frame; anything already buffered is a lost partial frame
            we     = 1'b1;
            waddr  = '0;
            wptr_n = ADDR_W'(1);
            drop_n = (wptr != '0);
          end else if (wptr == '0) begin
            drop_n = 1'b1;
          end else begin
            we     = 1'b1;
            waddr  = wptr;
            wptr_n = wptr + ADDR_W'(1);
          end
          if (we && (waddr == LAST_ADDR)) begin
            state_n   = RUN;
            wptr_n    = '0;
            run_cnt_n = '0;
            conv_n    = 1'b1;
          end
        end
      end
      RUN: begin
        run_cnt_n = run_cnt + CNT_W'(1);
        conv_n    = (run_cnt < START_LAST);
        // net_complete outranks the timeout when both land in the same cycle
        if (bus.net_complete) begin
          res_n   = '{cls: bus.net_out, timeout: 1'b0};
          rv_n    = 1'b1;
          conv_n  = 1'b0;
          state_n = DONE;
        end else if (run_cnt == RUN_LAST) begin
          res_n   = '{cls: CLASS_TIMEOUT, timeout: 1'b1};
          rv_n    = 1'b1;
          conv_n  = 1'b0;
          state_n = DONE;
        end
      end
      DONE: begin
        if (bus.result_ack) begin
          rv_n    = 1'b0;
          state_n = FILL;
        end
      end
      default: state_n = FILL;
    endcase
    ready_n = (state_n == FILL);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= FILL;
      wptr    <= '0;
      run_cnt <= '0;
      conv_q  <= 1'b0;
      ready_q <= 1'b0;
      drop_q  <= 1'b0;
      rv_q    <= 1'b0;
      res_q   <= '0;
    end else begin
      state   <= state_n;
      wptr    <= wptr_n;
      run_cnt <= run_cnt_n;
      conv_q  <= conv_n;
      ready_q <= ready_n;
      drop_q  <= drop_n;
      rv_q    <= rv_n;
      res_q   <= res_n;
    end
  end

  pixel_ram #(
    .DEPTH (IMG_PIX),
    .WIDTH (PIX_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (we),
    .waddr(waddr),
    .wdata(bus.pix_data),
    .raddr(bus.read_addr),
    .rdata(rd_data)
  );

  assign bus.pix_ready      = ready_q;
  assign bus.conv_start     = conv_q;
  assign bus.d_in           = rd_data;
  assign bus.result_valid   = rv_q;
  assign bus.result_class   = res_q.cls;
  assign bus.result_timeout = res_q.timeout;
  assign bus.frame_drop     = drop_q;
  assign bus.busy           = (state != FILL);
endmodule

// File: tb/tb_pixel_frame_server.sv
// Directed bench for pixel_frame_server: frame capture, run/result flow, framing errors, timeout, resets.
module tb_pixel_frame_server;
  localparam int IMG = 1024;
  localparam int PW  = 24;
  localparam int AW  = 11;
  localparam int SL  = 100;
  localparam int TO  = 300;

  logic clk = 1'b0;
  logic rst = 1'b0;

  pixel_frame_server_if #(.PIX_W(PW), .ADDR_W(AW)) bus ();

  pixel_frame_server #(
    .IMG_PIX(IMG), .PIX_W(PW), .ADDR_W(AW), .START_LEN(SL), .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [PW-1:0] model [IMG];
  logic [PW-1:0] exp_q [$];
  int mw = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  // one clock; the read scoreboard retires one expectation per cycle
  task automatic tick();
    logic [PW-1:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("d_in", 32'(bus.d_in), 32'(e));
    end
  endtask

  task automatic rd(input int a);
    bus.read_addr = AW'(a);
    exp_q.push_back((a < IMG) ? model[a] : '0);
  endtask

  task automatic beat(input logic sof, input logic [PW-1:0] dat);
    logic exp_drop;
    exp_drop = 1'b0;
    bus.pix_valid = 1'b1;
    bus.pix_sof   = sof;
    bus.pix_data  = dat;
    if (sof) begin
      exp_drop = (mw != 0);
      model[0] = dat;
      mw = 1;
    end else if (mw == 0) begin
      exp_drop = 1'b1;
    end else begin
      model[mw] = dat;
      mw = (mw == IMG - 1) ? 0 : mw + 1;
    end
    tick();
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    chk("frame_drop", 32'(bus.frame_drop), 32'(exp_drop));
  endtask

  task automatic frame(input logic [PW-1:0] xr);
    for (int i = 0; i < IMG; i++) begin
      if (i == IMG - 1) chk("pix_ready_before_last", 32'(bus.pix_ready), 32'd1);
      beat(i == 0, PW'(i) ^ xr);
    end
    chk("pix_ready_after_last", 32'(bus.pix_ready), 32'd0);
    chk("busy_run", 32'(bus.busy), 32'd1);
    chk("conv_start_first", 32'(bus.conv_start), 32'd1);
  endtask

  task automatic chk_zero(input string t);
    chk({t, ".pix_ready"}, 32'(bus.pix_ready), 32'd0);
    chk({t, ".conv_start"}, 32'(bus.conv_start), 32'd0);
    chk({t, ".d_in"}, 32'(bus.d_in), 32'd0);
    chk({t, ".result_valid"}, 32'(bus.result_valid), 32'd0);
    chk({t, ".result_class"}, 32'(bus.result_class), 32'd0);
    chk({t, ".result_timeout"}, 32'(bus.result_timeout), 32'd0);
    chk({t, ".frame_drop"}, 32'(bus.frame_drop), 32'd0);
    chk({t, ".busy"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic ack_to_fill(input string t);
    bus.result_ack = 1'b1;
    tick();
    bus.result_ack = 1'b0;
    chk({t, ".result_valid"}, 32'(bus.result_valid), 32'd0);
    chk({t, ".pix_ready"}, 32'(bus.pix_ready), 32'd1);
    chk({t, ".busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int n;
    bus.pix_valid    = 1'b0;
    bus.pix_sof      = 1'b0;
    bus.pix_data     = '0;
    bus.read_addr    = '0;
    bus.net_out      = '0;
    bus.net_complete = 1'b0;
    bus.result_ack   = 1'b0;

    tick();
    tick();
    chk_zero("reset");
    rst = 1'b1;
    tick();
    chk("pix_ready_after_reset", 32'(bus.pix_ready), 32'd1);

    // Frame A: data = address, watch conv_start width and the read port
    frame('0);
    for (int k = 0; k < 150; k++) begin
      chk("conv_start_level", 32'(bus.conv_start), 32'(k < SL));
      if (k == 11) begin
        chk("ack_in_run.result_valid", 32'(bus.result_valid), 32'd0);
        chk("ack_in_run.busy", 32'(bus.busy), 32'd1);
      end
      if (k == 0) rd(5);
      else if (k == 1) rd(1023);
      else if (k == 2) rd(1024);
      else if (k == 3) rd(2047);
      bus.result_ack = (k == 10);
      tick();
    end
    bus.net_complete = 1'b1;
    bus.net_out      = 8'd7;
    tick();
    bus.net_complete = 1'b0;
    bus.net_out      = 8'd0;
    chk("a.result_valid", 32'(bus.result_valid), 32'd1);
    chk("a.result_class", 32'(bus.result_class), 32'd7);
    chk("a.result_timeout", 32'(bus.result_timeout), 32'd0);
    chk("a.conv_start", 32'(bus.conv_start), 32'd0);
    tick();
    tick();
    chk("a.class_held", 32'(bus.result_class), 32'd7);
    chk("a.valid_held", 32'(bus.result_valid), 32'd1);
    ack_to_fill("a.ack");

    // Framing: SOF on beat 11 restarts the frame at address 0
    for (int i = 0; i < 10; i++) beat(i == 0, PW'(24'h100 + i));
    beat(1'b1, 24'hABCDEF);
    bus.result_ack = 1'b1;
    tick();
    bus.result_ack = 1'b0;
    chk("drop_single_pulse", 32'(bus.frame_drop), 32'd0);
    chk("ack_in_fill.busy", 32'(bus.busy), 32'd0);
    chk("ack_in_fill.pix_ready", 32'(bus.pix_ready), 32'd1);
    rd(0);
    tick();
    rd(1);
    tick();

    // Frame B: finish the restarted frame, net_complete at run cycle 40
    for (int i = 1; i < IMG; i++) beat(1'b0, PW'(i) ^ 24'h5A5A5A);
    chk("b.busy", 32'(bus.busy), 32'd1);
    for (int k = 0; k < 40; k++) begin
      chk("b.conv_start", 32'(bus.conv_start), 32'd1);
      if (k == 0) rd(1023);
      tick();
    end
    bus.net_complete = 1'b1;
    bus.net_out      = 8'd3;
    tick();
    bus.net_complete = 1'b0;
    chk("b.conv_start_fall", 32'(bus.conv_start), 32'd0);
    chk("b.result_valid", 32'(bus.result_valid), 32'd1);
    chk("b.result_class", 32'(bus.result_class), 32'd3);
    chk("b.result_timeout", 32'(bus.result_timeout), 32'd0);
    ack_to_fill("b.ack");

    // A non-SOF beat at wptr 0 is dropped and not written
    beat(1'b0, 24'h123456);
    tick();
    chk("nosof_single_pulse", 32'(bus.frame_drop), 32'd0);
    rd(0);
    tick();

    // Frame C: no net_complete, timeout after TO run cycles
    frame(24'hFFFFFF);
    n = 0;
    while (!bus.result_valid && n < 2 * TO) begin
      tick();
      n++;
    end
    chk("c.timeout_cycles", 32'(n), 32'(TO));
    chk("c.result_class", 32'(bus.result_class), 32'hFF);
    chk("c.result_timeout", 32'(bus.result_timeout), 32'd1);
    chk("c.conv_start", 32'(bus.conv_start), 32'd0);
    ack_to_fill("c.ack");

    // Frame D: net_complete lands in the timeout cycle and wins
    frame(24'h0F0F0F);
    for (int k = 0; k < TO - 1; k++) tick();
    chk("d.no_early_done", 32'(bus.result_valid), 32'd0);
    bus.net_complete = 1'b1;
    bus.net_out      = 8'h2A;
    tick();
    bus.net_complete = 1'b0;
    chk("d.result_valid", 32'(bus.result_valid), 32'd1);
    chk("d.result_class", 32'(bus.result_class), 32'h2A);
    chk("d.result_timeout", 32'(bus.result_timeout), 32'd0);
    ack_to_fill("d.ack");

    // Reset mid-FILL at wptr 500, with a live read keeping d_in non-zero
    bus.read_addr = AW'(3);
    for (int i = 0; i < 500; i++) beat(i == 0, PW'(i) + 24'h200000);
    chk("pre_reset.d_in", 32'(bus.d_in), 32'h200003);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    mw  = 0;
    chk_zero("rst_fill");
    tick();
    chk("rst_fill.pix_ready_after", 32'(bus.pix_ready), 32'd1);
    frame(24'h00FF00);

    // Reset mid-RUN
    for (int k = 0; k < 20; k++) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk_zero("rst_run");
    tick();
    chk("rst_run.pix_ready_after", 32'(bus.pix_ready), 32'd1);
    frame(24'h123123);
    for (int k = 0; k < 5; k++) tick();
    bus.net_complete = 1'b1;
    bus.net_out      = 8'd9;
    tick();
    bus.net_complete = 1'b0;
    chk("e.result_valid", 32'(bus.result_valid), 32'd1);
    chk("e.result_class", 32'(bus.result_class), 32'd9);
    chk("e.result_timeout", 32'(bus.result_timeout), 32'd0);
    ack_to_fill("e.ack");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
